// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg : shared constants and trace-entry type for the data-memory slave
// Revision 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int unsigned DEFAULT_MEM_SIZE_WORDS = 1024;
    localparam int unsigned DEFAULT_TRACE_DEPTH    = 8;
    localparam int unsigned DEFAULT_CYCLE_W        = 32;

    localparam logic [31:0] DONE_ADDR   = 32'h0000_0400;
    localparam logic [31:0] DONE_VALUE  = 32'h0000_0042;
    localparam logic [31:0] RESULT_BASE = 32'h0000_0300;

    localparam logic [3:0] WEN_WORD = 4'b1111;
    localparam logic [3:0] WEN_NONE = 4'b0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wen;
    } trace_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_ctrl_trace_fifo.sv
// ============================================================================
// trace_fifo : show-ahead FIFO with valid/ready pop and saturating drop count
// Revision 1.0
// ============================================================================
`default_nettype none

module trace_fifo #(
    parameter int unsigned WIDTH = 68,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [15:0]      drop_cnt_o
);

    localparam int unsigned  PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [WIDTH-1:0] slot_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic [WIDTH-1:0] last_q,   last_d;
    logic [15:0]      drop_q,   drop_d;

    logic w_pop;
    logic w_push;
    logic w_drop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_CNT);

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign w_pop  = pop_i && !empty_o;
    assign w_push = push_i && (!full_o || w_pop);
    assign w_drop = push_i && full_o && !w_pop;

    // While empty, the head shows the most recently popped entry.
    assign head_data_o = empty_o ? last_q : slot_q[rd_ptr_q];
    assign drop_cnt_o  = drop_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        drop_d   = drop_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            last_d   = slot_q[rd_ptr_q];
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (w_drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            slot_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            drop_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            drop_q   <= drop_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// data_mem_ctrl : word RAM with byte-lane stores, completion mailbox and store trace
// Revision 1.0
// ============================================================================
`default_nettype none

module data_mem_ctrl #(
    parameter int unsigned MEM_SIZE_WORDS = dmem_pkg::DEFAULT_MEM_SIZE_WORDS,
    parameter logic [31:0] DONE_ADDR      = dmem_pkg::DONE_ADDR,
    parameter logic [31:0] DONE_VALUE     = dmem_pkg::DONE_VALUE,
    parameter int unsigned TRACE_DEPTH    = dmem_pkg::DEFAULT_TRACE_DEPTH,
    parameter int unsigned CYCLE_W        = dmem_pkg::DEFAULT_CYCLE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        d_mem_addr_i,
    input  logic [31:0]        d_mem_wdata_i,
    input  logic [3:0]         d_mem_wen_i,
    output logic [31:0]        d_mem_rdata_o,
    output logic               trace_valid_o,
    input  logic               trace_ready_i,
    output logic [31:0]        trace_addr_o,
    output logic [31:0]        trace_data_o,
    output logic [3:0]         trace_wen_o,
    output logic [15:0]        trace_drop_cnt_o,
    output logic               err_oob_o,
    output logic               done_o,
    output logic [CYCLE_W-1:0] done_cycles_o
);

    import dmem_pkg::*;

    localparam int unsigned IDX_W     = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;
    localparam logic [33:0] MEM_BYTES = 34'(MEM_SIZE_WORDS) << 2;

    // RAM is deliberately outside the reset domain; its contents survive rst_n.
    logic [31:0] mem_q [MEM_SIZE_WORDS] = '{default: '0};

    logic [CYCLE_W-1:0] cycle_q,       cycle_d;
    logic [CYCLE_W-1:0] done_cycles_q, done_cycles_d;
    logic               done_q,        done_d;
    logic               err_oob_q,     err_oob_d;

    logic               w_wr;
    logic               w_in_range;
    logic [IDX_W-1:0]   w_idx;
    logic               w_done_hit;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    trace_entry_t       w_push_entry;
    trace_entry_t       w_head;

    assign w_wr       = (d_mem_wen_i != WEN_NONE);
    assign w_in_range = ({2'b00, d_mem_addr_i} < MEM_BYTES);
    assign w_idx      = d_mem_addr_i[IDX_W+1:2];
    assign w_done_hit = (d_mem_wen_i == WEN_WORD)
                     && (word_align(d_mem_addr_i) == DONE_ADDR)
                     && (d_mem_wdata_i == DONE_VALUE);

    assign d_mem_rdata_o = w_in_range ? mem_q[w_idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (w_wr && w_in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (d_mem_wen_i[k]) begin
                    mem_q[w_idx][8*k +: 8] <= d_mem_wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        cycle_d       = (&cycle_q) ? cycle_q : cycle_q + CYCLE_W'(1);
        done_d        = done_q;
        done_cycles_d = done_cycles_q;
        err_oob_d     = err_oob_q;

        // Only the first mailbox hit latches the cycle stamp.
        if (w_done_hit && !done_q) begin
            done_d        = 1'b1;
            done_cycles_d = cycle_q;
        end
        if (w_wr && !w_in_range) begin
            err_oob_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q       <= '0;
            done_q        <= 1'b0;
            done_cycles_q <= '0;
            err_oob_q     <= 1'b0;
        end else begin
            cycle_q       <= cycle_d;
            done_q        <= done_d;
            done_cycles_q <= done_cycles_d;
            err_oob_q     <= err_oob_d;
        end
    end

    assign w_push_entry = '{addr: word_align(d_mem_addr_i),
                            data: d_mem_wdata_i,
                            wen:  d_mem_wen_i};

    trace_fifo #(
        .WIDTH (($bits(trace_entry_t))),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_wr && w_in_range),
        .push_data_i (w_push_entry),
        .pop_i       (trace_ready_i),
        .head_data_o (w_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .drop_cnt_o  (trace_drop_cnt_o)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_full_not_empty: assert (!(w_fifo_full && w_fifo_empty));
        end
    end

    assign trace_valid_o = !w_fifo_empty;
    assign trace_addr_o  = w_head.addr;
    assign trace_data_o  = w_head.data;
    assign trace_wen_o   = w_head.wen;

    assign err_oob_o     = err_oob_q;
    assign done_o        = done_q;
    assign done_cycles_o = done_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// tb_data_mem_ctrl : directed stimulus checked against a queue/array memory model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] d_mem_addr = '0;
    logic [31:0] d_mem_wdata = '0;
    logic [3:0]  d_mem_wen = '0;
    logic        trace_ready = 1'b0;

    logic [31:0] d_mem_rdata;
    logic        trace_valid;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  trace_wen;
    logic [15:0] trace_drop_cnt;
    logic        err_oob;
    logic        done;
    logic [31:0] done_cycles;

    int n_vec  = 0;
    int n_fail = 0;

    data_mem_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .d_mem_addr_i     (d_mem_addr),
        .d_mem_wdata_i    (d_mem_wdata),
        .d_mem_wen_i      (d_mem_wen),
        .d_mem_rdata_o    (d_mem_rdata),
        .trace_valid_o    (trace_valid),
        .trace_ready_i    (trace_ready),
        .trace_addr_o     (trace_addr),
        .trace_data_o     (trace_data),
        .trace_wen_o      (trace_wen),
        .trace_drop_cnt_o (trace_drop_cnt),
        .err_oob_o        (err_oob),
        .done_o           (done),
        .done_cycles_o    (done_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [1024] = '{default: '0};
    logic [67:0] m_q [$];
    logic [67:0] m_last = '0;
    logic [15:0] m_drop = '0;
    logic        m_err = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_done_cyc = '0;
    logic [31:0] m_cycle = '0;
    int          m_pre;
    bit          m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_last = '0; m_drop = '0; m_err = 1'b0;
            m_done = 1'b0; m_done_cyc = '0; m_cycle = '0;
        end else begin
            m_pre = m_q.size();
            m_pop = (m_pre > 0) && trace_ready;
            if (m_pop) m_last = m_q.pop_front();
            if (d_mem_wen != 4'b0000) begin
                if (d_mem_addr < 32'h1000) begin
                    for (int k = 0; k < 4; k++)
                        if (d_mem_wen[k]) m_mem[d_mem_addr[11:2]][8*k +: 8] = d_mem_wdata[8*k +: 8];
                    if (m_pre < 8 || m_pop)
                        m_q.push_back({d_mem_addr & ~32'h3, d_mem_wdata, d_mem_wen});
                    else if (m_drop != 16'hFFFF)
                        m_drop = m_drop + 16'd1;
                end else begin
                    m_err = 1'b1;
                end
                if (d_mem_wen == 4'hF && (d_mem_addr & ~32'h3) == 32'h400
                    && d_mem_wdata == 32'h42 && !m_done) begin
                    m_done = 1'b1;
                    m_done_cyc = m_cycle;
                end
            end
            if (m_cycle != 32'hFFFF_FFFF) m_cycle = m_cycle + 32'd1;
        end
    end

    logic [67:0] c_head;
    logic [31:0] c_rd;

    always @(negedge clk) begin
        c_rd   = (d_mem_addr < 32'h1000) ? m_mem[d_mem_addr[11:2]] : 32'h0;
        c_head = (m_q.size() > 0) ? m_q[0] : m_last;
        chk("rdata",       d_mem_rdata,    c_rd);
        chk("trace_valid", trace_valid,    (m_q.size() > 0) ? 32'd1 : 32'd0);
        chk("trace_addr",  trace_addr,     c_head[67:36]);
        chk("trace_data",  trace_data,     c_head[35:4]);
        chk("trace_wen",   trace_wen,      c_head[3:0]);
        chk("drop_cnt",    trace_drop_cnt, m_drop);
        chk("err_oob",     err_oob,        m_err);
        chk("done",        done,           m_done);
        chk("done_cycles", done_cycles,    m_done_cyc);
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w, input logic r);
        d_mem_addr = a; d_mem_wdata = d; d_mem_wen = w; trace_ready = r;
        @(negedge clk); #1;
    endtask

    task automatic idle(input logic r);
        step(32'h0, 32'h0, 4'h0, r);
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        d_mem_addr = a; d_mem_wdata = '0; d_mem_wen = 4'h0; trace_ready = 1'b0;
        #1;
        chk(name, d_mem_rdata, exp);
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(1'b0);
        idle(1'b0);
        rst_n = 1'b1;
    endtask

    logic [3:0] wen_tab [11] = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h5, 4'hA, 4'hF, 4'h6};

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rst trace_valid", trace_valid, 32'd0);
        chk("rst done", done, 32'd0);
        chk("rst err_oob", err_oob, 32'd0);
        chk("rst drop", trace_drop_cnt, 32'd0);
        chk("rst done_cycles", done_cycles, 32'd0);
        idle(1'b0);
        rst_n = 1'b1;

        // byte lanes
        step(32'h10, 32'hAABBCCDD, 4'hF, 1'b1);
        step(32'h10, 32'h11223344, 4'h5, 1'b1);
        read_check("lanes 0x10", 32'h10, 32'hAA22CC44);
        read_check("lanes 0x13", 32'h13, 32'hAA22CC44);

        // completion mailbox at cycle 37
        do_reset();
        step(32'h300, 32'd3, 4'hF, 1'b1);
        step(32'h304, 32'd2, 4'hF, 1'b1);
        step(32'h308, 32'd1, 4'hF, 1'b1);
        repeat (34) idle(1'b1);
        step(32'h400, 32'h42, 4'hF, 1'b1);
        chk("done set", done, 32'd1);
        chk("done_cycles first", done_cycles, 32'd37);
        step(32'h400, 32'h42, 4'hF, 1'b1);
        chk("done_cycles kept", done_cycles, 32'd37);
        do_reset();
        step(32'h400, 32'h42, 4'h1, 1'b1);
        chk("partial no done", done, 32'd0);
        idle(1'b1);

        // out of range
        step(32'h1000, 32'hDEADBEEF, 4'hF, 1'b0);
        chk("oob err", err_oob, 32'd1);
        chk("oob no trace", trace_valid, 32'd0);
        read_check("oob read", 32'h1000, 32'h0);
        read_check("oob no alias", 32'h0, 32'h0);
        step(32'hFFC, 32'h12345678, 4'hF, 1'b1);
        read_check("last word", 32'hFFC, 32'h12345678);

        // FIFO fill and drop
        do_reset();
        for (int i = 0; i < 10; i++)
            step(32'h100 + 32'(4*i), 32'hC0DE_0000 + 32'(i), wen_tab[i], 1'b0);
        chk("drop after 10", trace_drop_cnt, 32'd2);
        chk("full head addr", trace_addr, 32'h100);
        chk("full head data", trace_data, 32'hC0DE_0000);
        chk("full head wen", trace_wen, 32'hF);
        step(32'h128, 32'hC0DE_000A, wen_tab[10], 1'b1);
        chk("push+pop drop", trace_drop_cnt, 32'd2);

        // drain: entries 1..7 then the entry pushed while full
        for (int j = 0; j < 8; j++) begin
            chk("drain valid", trace_valid, 32'd1);
            chk("drain addr", trace_addr, 32'h100 + 32'(4*((j < 7) ? j+1 : 10)));
            chk("drain data", trace_data, 32'hC0DE_0000 + 32'((j < 7) ? j+1 : 10));
            chk("drain wen", trace_wen, {28'h0, wen_tab[(j < 7) ? j+1 : 10]});
            idle(1'b1);
        end
        chk("drained valid", trace_valid, 32'd0);
        chk("drained hold", trace_addr, 32'h128);

        // reset mid-run
        step(32'h400, 32'h42, 4'hF, 1'b0);
        step(32'h300, 32'd3, 4'hF, 1'b0);
        step(32'h304, 32'd2, 4'hF, 1'b0);
        chk("pre-rst valid", trace_valid, 32'd1);
        chk("pre-rst done", done, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid-rst valid", trace_valid, 32'd0);
        chk("mid-rst done", done, 32'd0);
        chk("mid-rst done_cycles", done_cycles, 32'd0);
        chk("mid-rst drop", trace_drop_cnt, 32'd0);
        @(negedge clk); #1;
        idle(1'b0);
        rst_n = 1'b1;
        read_check("ram kept 0x300", 32'h300, 32'd3);
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Synthesizable data-memory slave on the CPU's d_mem bus, directly downstream of cpu_top's load/store port. It provides word-addressed RAM with byte-lane writes and combinational reads, and detects the program-completion mailbox write. It also logs every accepted store into a small trace FIFO, drained by a logger/monitor over a valid/ready handshake. It replaces the bench-side behavioural RAM so benches and FPGA builds share one memory model.

Parameters:
MEM_SIZE_WORDS, 1024, RAM depth in 32-bit words; byte range is 0 .. 4*MEM_SIZE_WORDS-1.
DONE_ADDR, 32'h0000_0400, byte address of the completion mailbox word.
DONE_VALUE, 32'h0000_0042, value that signals program completion.
TRACE_DEPTH, 8, trace FIFO entries; must be a power of two, minimum 2.
CYCLE_W, 32, width of the cycle counter and done_cycles.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
d_mem_addr  in  32  CPU byte address; bits [1:0] are ignored (word access).
d_mem_wdata  in  32  store data, lane-aligned.
d_mem_wen  in  4  byte-lane write enables; bit k writes byte k (bits 8k+7:8k); 4'b0000 means read/idle.
d_mem_rdata  out  32  combinational read data.
trace_valid  out  1  trace FIFO head is valid.
trace_ready  in  1  consumer accepts the head this cycle.
trace_addr  out  32  word-aligned address of the head store.
trace_data  out  32  wdata of the head store.
trace_wen  out  4  lane mask of the head store.
trace_drop_cnt  out  16  stores lost because the FIFO was full.
err_oob  out  1  sticky; an out-of-range write occurred.
done  out  1  sticky; the completion mailbox was written.
done_cycles  out  CYCLE_W  cycle count captured at the mailbox write.

Behaviour:
- Reset (async assert, sync release): trace_valid=0, trace FIFO flushed, trace_addr/data/wen=0, trace_drop_cnt=0, err_oob=0, done=0, done_cycles=0, cycle counter=0. RAM contents are not affected by rst_n; RAM is zero-initialised at time 0.
- Reads: d_mem_rdata = mem[d_mem_addr[31:2]] when d_mem_addr < 4*MEM_SIZE_WORDS, else 32'h0. Zero cycles of latency. The read-during-write cycle returns the old word.
- Writes: on a rising edge with d_mem_wen != 0:
  - In range: only enabled lanes are updated; disabled lanes are preserved.
  - Out of range: RAM is unchanged, err_oob <= 1, and nothing is pushed to the trace FIFO.
- Cycle counter: increments every cycle after reset release and saturates at all-ones.
- Done detection: fires when d_mem_wen==4'b1111, {d_mem_addr[31:2],2'b00}==DONE_ADDR and d_mem_wdata==DONE_VALUE.
  - On that edge, done <= 1 and done_cycles <= the current cycle counter value, sampled before increment.
  - Only the first hit is captured. Later hits leave done_cycles unchanged.
  - A partial-lane write, or a wrong value, to DONE_ADDR does not fire, but the RAM write still occurs.
  - Stores after done proceed normally.
- Trace FIFO: show-ahead, TRACE_DEPTH entries.
  - Push: every in-range write pushes {addr word-aligned, wdata, wen}.
  - Pop: occurs when trace_valid && trace_ready.
  - Push latency: an entry pushed at edge N appears on trace_valid after edge N when the FIFO was empty.
  - Full with no pop in the same cycle: the push is dropped and trace_drop_cnt increments, saturating at 16'hFFFF.
  - Full with a simultaneous push and pop: both succeed and the FIFO stays full.
  - Empty: trace_valid=0 and trace_ready is ignored.
  - Head fields hold their last popped values while the FIFO is empty.
- Reset mid-operation: the FIFO and all flags and counters clear immediately. RAM retains written data.

Decomposition:
- Shared package dmem_pkg: MEM_SIZE_WORDS default, DONE_ADDR, DONE_VALUE, RESULT_BASE=32'h300, WEN_WORD=4'b1111, WEN_NONE=4'b0000, and a typedef for the trace entry (addr 32, data 32, wen 4 = 68 bits).
- Sub-module trace_fifo: parameterised width and depth, valid/ready pop, full/empty outputs, and a drop-count output.
- data_mem_ctrl instantiates trace_fifo and holds the RAM array, done detection and counters.

Test Plan:
- Byte lanes: write 32'hAABBCCDD with wen=1111 to 0x10, then 32'h11223344 with wen=0101 -> reading 0x10 returns 32'hAA22CC44. Reading 0x13 returns the same word.
- Completion: write 3,2,1 to 0x300..0x308, then 0x42 full-word to 0x400 at cycle 37 -> done=1 on the next edge and done_cycles=37. A second 0x42 write leaves done_cycles=37. Writing 0x42 with wen=0001 to 0x400 in a fresh run leaves done=0.
- Out of range: write to 0x1000 with MEM_SIZE_WORDS=1024 -> err_oob=1, mem unchanged, read of 0x1000 returns 0, and no trace entry.
- FIFO full/drop: trace_ready=0, 10 stores with depth 8 -> 8 entries in order, trace_drop_cnt=2. Then full with a simultaneous push and pop (trace_ready=1) -> the FIFO stays full and the drop count stays at 2.
- Drain order: after the stores above, pulse trace_ready -> entries emerge in original order with exact addr/data/wen. trace_valid drops after the 8th pop.
- Reset mid-run: assert rst_n=0 with 3 FIFO entries and done=1 -> trace_valid, done and counters are 0 immediately. After release, reading 0x300 still returns 3.
